execute_iter: RTL and testbench

Parametrised execute stage that replaces the fixed 32-bit single-cycle execute stage. It does single-cycle add/sub/carry/logic operations and iterative radix-2 multiply and divide. It sits between decode/register-read and the memory/writeback stage. It keeps the valid/stall pipeline handshake and a persistent carry flag, and adds internal back-pressure while a multi-cycle operation is in flight.

---
 rtl/execute_iter.sv | 189 ++++++++++++++++++
 tb/tb_execute_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_iter.sv
// Execute stage: single-cycle add/sub/carry/logic ops plus iterative radix-2
// multiply and restoring divide, behind a valid/stall pipeline handshake.
module execute_iter #(
   parameter int WIDTH       = 32,
   parameter int LEN_OPECODE = 7,
   parameter int LEN_IMM     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_i,
   input  logic                   stall_i,
   output logic                   stall_o,
   output logic                   valid_o,
   input  logic [LEN_OPECODE-1:0] opecode,
   input  logic                   immf,
   input  logic [WIDTH-1:0]       data_rd,
   input  logic [WIDTH-1:0]       data_rs,
   input  logic [LEN_IMM-1:0]     imm,
   output logic [WIDTH-1:0]       data_o,
   output logic                   carry_o,
   output logic                   div0_o
);

   localparam int CNT_W = ($clog2(WIDTH) < 5) ? 5 : $clog2(WIDTH);

   localparam logic [LEN_OPECODE-1:0] OP_ADD = LEN_OPECODE'(7'b000_0000);
   localparam logic [LEN_OPECODE-1:0] OP_SUB = LEN_OPECODE'(7'b000_0001);
   localparam logic [LEN_OPECODE-1:0] OP_MUL = LEN_OPECODE'(7'b000_0010);
   localparam logic [LEN_OPECODE-1:0] OP_DIV = LEN_OPECODE'(7'b000_0011);
   localparam logic [LEN_OPECODE-1:0] OP_ADC = LEN_OPECODE'(7'b000_0100);
   localparam logic [LEN_OPECODE-1:0] OP_SBC = LEN_OPECODE'(7'b000_0101);
   localparam logic [LEN_OPECODE-1:0] OP_AND = LEN_OPECODE'(7'b001_0000);
   localparam logic [LEN_OPECODE-1:0] OP_OR  = LEN_OPECODE'(7'b001_0001);
   localparam logic [LEN_OPECODE-1:0] OP_XOR = LEN_OPECODE'(7'b001_0010);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             is_mul_reg;
   logic             div0_pend_reg;
   logic [WIDTH-1:0] rem_reg;   // mul: accumulator, div: partial remainder
   logic [WIDTH-1:0] quo_reg;   // mul: multiplier, div: dividend shifting into quotient
   logic [WIDTH-1:0] dvs_reg;   // mul: multiplicand, div: divisor
   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;
   logic             carry_reg;
   logic             div0_reg;

   logic             hold;
   logic             accept;
   logic             is_iter;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] operand_b;
   logic             cin;
   logic [WIDTH:0]   add_ext;
   logic [WIDTH:0]   sub_ext;
   logic [WIDTH-1:0] alu_data;
   logic             alu_carry;

   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   assign hold    = valid_reg & stall_i;
   assign stall_o = (state_reg != IDLE) | hold;
   assign accept  = valid_i & ~stall_o;
   assign is_iter = (opecode == OP_MUL) | (opecode == OP_DIV);

   assign imm_sext  = WIDTH'($signed(imm));
   assign operand_b = immf ? imm_sext : data_rs;

   assign cin     = ((opecode == OP_ADC) | (opecode == OP_SBC)) & carry_reg;
   assign add_ext = {1'b0, data_rd} + {1'b0, operand_b} + (WIDTH+1)'(cin);
   // Bit WIDTH of the wrapped difference is the borrow out.
   assign sub_ext = {1'b0, data_rd} - {1'b0, operand_b} - (WIDTH+1)'(cin);

   always_comb begin
      alu_data  = '0;
      alu_carry = carry_reg;
      case (opecode)
         OP_ADD, OP_ADC: begin
            alu_data  = add_ext[WIDTH-1:0];
            alu_carry = add_ext[WIDTH];
         end
         OP_SUB, OP_SBC: begin
            alu_data  = sub_ext[WIDTH-1:0];
            alu_carry = sub_ext[WIDTH];
         end
         OP_AND:  alu_data = data_rd & operand_b;
         OP_OR:   alu_data = data_rd | operand_b;
         OP_XOR:  alu_data = data_rd ^ operand_b;
         default: alu_data = '0;
      endcase
   end

   // One iteration: MSB-first shift-add for mul, restoring subtract-shift for div.
   assign mul_acc   = {rem_reg[WIDTH-2:0], 1'b0} + (quo_reg[WIDTH-1] ? dvs_reg : '0);
   assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, dvs_reg};

   always_comb begin
      rem_next = mul_acc;
      quo_next = {quo_reg[WIDTH-2:0], 1'b0};
      if (!is_mul_reg) begin
         if (!div_diff[WIDTH]) begin
            rem_next = div_diff[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
         end else begin
            rem_next = div_shift[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         is_mul_reg    <= 1'b0;
         div0_pend_reg <= 1'b0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         dvs_reg       <= '0;
         valid_reg     <= 1'b0;
         data_reg      <= '0;
         carry_reg     <= 1'b0;
         div0_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (is_iter) begin
                     state_reg     <= BUSY;
                     cnt_reg       <= CNT_W'(WIDTH - 1);
                     is_mul_reg    <= (opecode == OP_MUL);
                     div0_pend_reg <= (opecode == OP_DIV) && (operand_b == '0);
                     rem_reg       <= '0;
                     quo_reg       <= (opecode == OP_MUL) ? operand_b : data_rd;
                     dvs_reg       <= (opecode == OP_MUL) ? data_rd : operand_b;
                     valid_reg     <= 1'b0;
                  end else begin
                     data_reg  <= alu_data;
                     carry_reg <= alu_carry;
                     valid_reg <= 1'b1;
                     div0_reg  <= 1'b0;
                  end
               end else if (!hold) begin
                  valid_reg <= 1'b0;
               end
            end
            BUSY: begin
               if (!hold) begin
                  valid_reg <= 1'b0;
               end
               rem_reg <= rem_next;
               quo_reg <= quo_next;
               if (cnt_reg == '0) begin
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            DONE: begin
               // The result waits here until any held output has drained.
               if (!hold) begin
                  data_reg  <= is_mul_reg ? rem_reg : quo_reg;
                  valid_reg <= 1'b1;
                  div0_reg  <= div0_pend_reg;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign valid_o = valid_reg;
   assign data_o  = data_reg;
   assign carry_o = carry_reg;
   assign div0_o  = div0_reg;

endmodule

// File: tb/tb_execute_iter.sv
// Directed bench for execute_iter: expected results are queued at issue time
// and a negedge monitor pops and compares each new output transaction.
module tb_execute_iter;

   localparam int W = 32;

   localparam logic [6:0] OP_ADD = 7'b000_0000;
   localparam logic [6:0] OP_SUB = 7'b000_0001;
   localparam logic [6:0] OP_MUL = 7'b000_0010;
   localparam logic [6:0] OP_DIV = 7'b000_0011;
   localparam logic [6:0] OP_ADC = 7'b000_0100;
   localparam logic [6:0] OP_SBC = 7'b000_0101;
   localparam logic [6:0] OP_AND = 7'b001_0000;
   localparam logic [6:0] OP_OR  = 7'b001_0001;
   localparam logic [6:0] OP_XOR = 7'b001_0010;
   localparam logic [6:0] OP_BAD = 7'b111_1111;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0;
   logic          stall_i = 1'b0;
   logic          stall_o;
   logic          valid_o;
   logic [6:0]    opecode = '0;
   logic          immf = 1'b0;
   logic [W-1:0]  data_rd = '0;
   logic [W-1:0]  data_rs = '0;
   logic [15:0]   imm = '0;
   logic [W-1:0]  data_o;
   logic          carry_o;
   logic          div0_o;

   typedef struct packed {
      logic [W-1:0] data;
      logic         carry;
      logic         div0;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   prev_hold = 1'b0;

   execute_iter #(.WIDTH(W), .LEN_OPECODE(7), .LEN_IMM(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .stall_i (stall_i),
      .stall_o (stall_o),
      .valid_o (valid_o),
      .opecode (opecode),
      .immf    (immf),
      .data_rd (data_rd),
      .data_rs (data_rs),
      .imm     (imm),
      .data_o  (data_o),
      .carry_o (carry_o),
      .div0_o  (div0_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Presents an op and holds it until accepted; queues its expected result.
   task automatic issue(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic imf, input logic [15:0] im,
                        input logic [W-1:0] ed, input logic ec, input logic e0, input bit push);
      int n;
      exp_t e;
      opecode = op;
      data_rd = a;
      data_rs = b;
      immf    = imf;
      imm     = im;
      valid_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (stall_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (stall_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout op=%h actual=stalled required=accepted", op);
      end else if (push) begin
         e.data  = ed;
         e.carry = ec;
         e.div0  = e0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask

   // Monitor: a result is new when valid_o is high and was not held across the last edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         prev_hold = 1'b0;
      end else begin
         if (valid_o && !prev_hold) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result data_o=%h carry_o=%b div0_o=%b required=none",
                        data_o, carry_o, div0_o);
            end else begin
               e = exp_q.pop_front();
               if (data_o !== e.data || carry_o !== e.carry || div0_o !== e.div0) begin
                  errors++;
                  $display("FAIL result data_o=%h carry_o=%b div0_o=%b required data=%h carry=%b div0=%b",
                           data_o, carry_o, div0_o, e.data, e.carry, e.div0);
               end else begin
                  $display("result data_o=%h carry_o=%b div0_o=%b ok", data_o, carry_o, div0_o);
               end
            end
         end
         prev_hold = valid_o & stall_i;
      end
   end

   initial begin
      int bad;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", W'(valid_o), '0);
      check("reset_data", data_o, '0);
      check("reset_carry", W'(carry_o), '0);
      check("reset_div0", W'(div0_o), '0);
      check("reset_stall", W'(stall_o), '0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Carry chain, back to back.
      issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      issue(OP_ADC, 32'h0, 32'h1234, 1'b1, 16'h0, 32'h1, 1'b0, 1'b0, 1'b1);
      issue(OP_SUB, 32'd3, 32'd5, 1'b0, 16'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
      issue(OP_SBC, 32'd10, 32'd2, 1'b0, 16'h0, 32'd7, 1'b0, 1'b0, 1'b1);
      issue(OP_ADD, 32'd5, 32'h0, 1'b1, 16'hFFFF, 32'd4, 1'b1, 1'b0, 1'b1);
      issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 16'h0, 32'h0000_00F0, 1'b1, 1'b0, 1'b1);
      issue(OP_OR,  32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 16'h0, 32'h0000_FFF0, 1'b1, 1'b0, 1'b1);
      issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 16'h0, 32'h0000_FF00, 1'b1, 1'b0, 1'b1);
      issue(OP_BAD, 32'h1234_5678, 32'h1, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      issue(OP_ADC, 32'd1, 32'd1, 1'b0, 16'h0, 32'd3, 1'b0, 1'b0, 1'b1);
      issue(OP_SBC, 32'd0, 32'd0, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Multiply latency and busy flags.
      issue(OP_MUL, 32'h0001_0001, 32'h0001_0001, 1'b0, 16'h0, 32'h0002_0001, 1'b0, 1'b0, 1'b1);
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (stall_o !== 1'b1 || valid_o !== 1'b0) bad++;
      end
      check("mul_busy_flags_bad_cycles", W'(bad), '0);
      @(negedge clk);
      check("mul_latency_valid", W'(valid_o), W'(1));
      check("mul_latency_stall", W'(stall_o), '0);
      check("mul_latency_data", data_o, 32'h0002_0001);
      @(posedge clk);
      #1;

      issue(OP_DIV, 32'd100, 32'd7, 1'b0, 16'h0, 32'd14, 1'b0, 1'b0, 1'b1);
      issue(OP_DIV, 32'd5, 32'd0, 1'b0, 16'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);

      // Output hold after a multi-cycle result.
      issue(OP_MUL, 32'd3, 32'd4, 1'b0, 16'h0, 32'd12, 1'b0, 1'b0, 1'b1);
      repeat (32) @(posedge clk);
      #1 stall_i = 1'b1;
      fork
         begin
            repeat (4) @(posedge clk);
            #1 stall_i = 1'b0;
         end
         begin
            @(posedge clk);
            bad = 0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (data_o !== 32'd12 || valid_o !== 1'b1 || stall_o !== 1'b1) bad++;
            end
            check("hold_frozen_bad_cycles", W'(bad), '0);
         end
         issue(OP_ADD, 32'd7, 32'd8, 1'b0, 16'h0, 32'd15, 1'b0, 1'b0, 1'b1);
      join

      // Reset in the middle of a divide.
      issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      issue(OP_DIV, 32'd1000, 32'd3, 1'b0, 16'h0, 32'd333, 1'b1, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_valid", W'(valid_o), '0);
      check("abort_stall", W'(stall_o), '0);
      check("abort_carry", W'(carry_o), '0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      issue(OP_ADD, 32'd1, 32'd2, 1'b0, 16'h0, 32'd3, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("post_reset_add_valid", W'(valid_o), W'(1));
      check("post_reset_add_data", data_o, 32'd3);

      repeat (40) @(posedge clk);
      #1;
      check("queue_drained", W'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
